// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - word-port load/store initiator with sub-word extend and RMW stores
module load_store_unit #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    localparam logic [31:0] ADDR_LIMIT = 32'(MEM_WORDS * 4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERR,
        S_LOAD,
        S_STORE,
        S_RMW_RD,
        S_RMW_WR,
        S_RESP
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_lane;
    logic [15:0] r_wdata;
    logic [31:0] r_rdata;
    logic [31:0] r_mem_address;
    logic [31:0] r_mem_write_data;

    logic        w_accept;
    logic        w_err;
    logic [4:0]  w_shamt;
    logic [31:0] w_shifted;
    logic [31:0] w_load_data;
    logic [31:0] w_lane_mask;
    logic [31:0] w_merged;

    assign w_accept = req_valid && (r_state == S_IDLE);
    assign w_err    = (req_size == 2'b11)
                   || (req_size == 2'b01 && req_addr[0])
                   || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                   || (req_addr >= ADDR_LIMIT);

    // Lane offset in bits; halfword requests are aligned so this is 0 or 16 for them.
    assign w_shamt   = {r_lane, 3'b000};
    assign w_shifted = mem_read_data >> w_shamt;

    always_comb begin
        w_load_data = mem_read_data;
        case (r_size)
            2'b00:   w_load_data = {{24{~r_unsigned & w_shifted[7]}}, w_shifted[7:0]};
            2'b01:   w_load_data = {{16{~r_unsigned & w_shifted[15]}}, w_shifted[15:0]};
            default: w_load_data = mem_read_data;
        endcase
    end

    assign w_lane_mask = (r_size == 2'b00) ? (32'h0000_00FF << w_shamt)
                                           : (32'h0000_FFFF << w_shamt);
    assign w_merged    = (mem_read_data & ~w_lane_mask)
                       | (({16'h0000, r_wdata} << w_shamt) & w_lane_mask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        resp_rdata = 32'h0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (w_err)                 w_next = S_ERR;
                    else if (!req_we)          w_next = S_LOAD;
                    else if (req_size == 2'b10) w_next = S_STORE;
                    else                       w_next = S_RMW_RD;
                end
            end
            S_ERR: begin
                resp_valid = 1'b1;
                resp_err   = 1'b1;
                w_next     = S_IDLE;
            end
            S_LOAD: begin
                mem_read = 1'b1;
                w_next   = S_RESP;
            end
            S_STORE: begin
                mem_write = 1'b1;
                w_next    = S_RESP;
            end
            S_RMW_RD: begin
                mem_read = 1'b1;
                w_next   = S_RMW_WR;
            end
            S_RMW_WR: begin
                mem_write = 1'b1;
                w_next    = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_rdata = r_rdata;
                w_next     = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Address/write-data only move for accesses that touch memory, so they hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_size           <= 2'b00;
            r_unsigned       <= 1'b0;
            r_lane           <= 2'b00;
            r_wdata          <= 16'h0;
            r_rdata          <= 32'h0;
            r_mem_address    <= 32'h0;
            r_mem_write_data <= 32'h0;
        end else begin
            if (w_accept) begin
                r_size     <= req_size;
                r_unsigned <= req_unsigned;
                r_lane     <= req_addr[1:0];
                r_wdata    <= req_wdata[15:0];
                r_rdata    <= 32'h0;
                if (!w_err) begin
                    r_mem_address <= {req_addr[31:2], 2'b00};
                    if (req_we && req_size == 2'b10) begin
                        r_mem_write_data <= req_wdata;
                    end
                end
            end
            if (r_state == S_LOAD) begin
                r_rdata <= w_load_data;
            end
            if (r_state == S_RMW_RD) begin
                r_mem_write_data <= w_merged;
            end
        end
    end

    assign mem_address    = r_mem_address;
    assign mem_write_data = r_mem_write_data;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed vector bench for load_store_unit with a word memory model
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    load_store_unit #(.MEM_WORDS(1024)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_we         (req_we),
        .req_size       (req_size),
        .req_unsigned   (req_unsigned),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_rdata     (resp_rdata),
        .resp_err       (resp_err),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [0:1023];
    assign mem_read_data = mem[mem_address[11:2]];
    always @(posedge clk) begin
        if (mem_write) mem[mem_address[11:2]] <= mem_write_data;
    end

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    int resp_cnt = 0;
    int overlap = 0;
    logic [31:0] last_addr = 32'h0;

    always @(negedge clk) begin
        if (mem_read)  rd_cnt++;
        if (mem_write) wr_cnt++;
        if (mem_read || mem_write) last_addr = mem_address;
        if (mem_read && mem_write) overlap++;
        if (resp_valid) resp_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
    } vec_t;

    vec_t vecs[$];

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        logic [31:0] rdata;
        logic err;
        string tag;
        tag = $sformatf("v%0d", idx);
        lat = -1;
        rdata = 32'h0;
        err = 1'b0;
        @(negedge clk);
        chk({tag, "_ready"}, {31'h0, req_ready}, 32'h1);
        req_valid    = 1'b1;
        req_we       = v.we;
        req_size     = v.size;
        req_unsigned = v.uns;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'h0;
        rd_cnt = 0;
        wr_cnt = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat   = c;
                rdata = resp_rdata;
                err   = resp_err;
                break;
            end
        end
        chk({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
        chk({tag, "_rdata"}, rdata, v.exp_rdata);
        chk({tag, "_err"}, {31'h0, err}, {31'h0, v.exp_err});
        chk({tag, "_rd_cnt"}, 32'(rd_cnt), 32'(v.exp_rd));
        chk({tag, "_wr_cnt"}, 32'(wr_cnt), 32'(v.exp_wr));
        if (v.exp_rd + v.exp_wr > 0)
            chk({tag, "_mem_addr"}, last_addr, {v.addr[31:2], 2'b00});
    endtask

    int first_c;
    int second_c;
    logic [31:0] first_d;
    logic [31:0] second_d;
    int resp_before;

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_size = 2'b00;
        req_unsigned = 1'b0;
        req_addr = 32'h0;
        req_wdata = 32'h0;

        //            we    size   uns   addr          wdata         rdata         err  lat rd wr
        vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,        1'b0, 2, 0, 1});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0,        32'hDEAD_BEEF, 1'b0, 2, 1, 0});
        vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h0000_0020, 32'h1122_3344, 32'h0,        1'b0, 2, 0, 1});
        vecs.push_back('{1'b1, 2'b00, 1'b0, 32'h0000_0022, 32'h0000_00AA, 32'h0,        1'b0, 3, 1, 1});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h0000_0020, 32'h0,        32'h11AA_3344, 1'b0, 2, 1, 0});
        vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h0000_0030, 32'h0000_F080, 32'h0,        1'b0, 2, 0, 1});
        vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h0000_0030, 32'h0,        32'hFFFF_FF80, 1'b0, 2, 1, 0});
        vecs.push_back('{1'b0, 2'b00, 1'b1, 32'h0000_0030, 32'h0,        32'h0000_0080, 1'b0, 2, 1, 0});
        vecs.push_back('{1'b0, 2'b01, 1'b0, 32'h0000_0030, 32'h0,        32'hFFFF_F080, 1'b0, 2, 1, 0});
        vecs.push_back('{1'b0, 2'b01, 1'b1, 32'h0000_0030, 32'h0,        32'h0000_F080, 1'b0, 2, 1, 0});
        vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h0000_0031, 32'h0,        32'hFFFF_FFF0, 1'b0, 2, 1, 0});
        vecs.push_back('{1'b1, 2'b01, 1'b0, 32'h0000_0032, 32'h1234_ABCD, 32'h0,        1'b0, 3, 1, 1});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h0000_0030, 32'h0,        32'hABCD_F080, 1'b0, 2, 1, 0});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h0000_0013, 32'h0,        32'h0,        1'b1, 1, 0, 0});
        vecs.push_back('{1'b1, 2'b01, 1'b0, 32'h0000_0021, 32'h5555_5555, 32'h0,        1'b1, 1, 0, 0});
        vecs.push_back('{1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0,        32'h0,        1'b1, 1, 0, 0});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0,        32'h0,        1'b1, 1, 0, 0});
        vecs.push_back('{1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h0,        32'h0,        1'b1, 1, 0, 0});
        vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h0000_0FFC, 32'hCAFE_F00D, 32'h0,        1'b0, 2, 0, 1});
        vecs.push_back('{1'b0, 2'b01, 1'b1, 32'h0000_0FFE, 32'h0,        32'h0000_CAFE, 1'b0, 2, 1, 0});
        vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h0000_0040, 32'h5566_7788, 32'h0,        1'b0, 2, 0, 1});

        repeat (3) @(negedge clk);
        chk("rst_req_ready",  {31'h0, req_ready},  32'h1);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_resp_err",   {31'h0, resp_err},   32'h0);
        chk("rst_mem_rw",     {30'h0, mem_read, mem_write}, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_mem_addr",   mem_address, 32'h0);
        chk("rst_mem_wdata",  mem_write_data, 32'h0);
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i], i);

        // Back-to-back: req_valid held high, address changed right after the first accept.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h0000_0010; req_wdata = 32'h0;
        @(posedge clk);
        #1;
        req_addr = 32'h0000_0030;
        first_c = -1; second_c = -1; first_d = 32'h0; second_d = 32'h0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c <= 2) chk($sformatf("b2b_ready_low_c%0d", c), {31'h0, req_ready}, 32'h0);
            if (c == 3) chk("b2b_ready_high", {31'h0, req_ready}, 32'h1);
            if (c == 4) req_valid = 1'b0;
            if (resp_valid) begin
                if (first_c < 0) begin
                    first_c = c; first_d = resp_rdata;
                end else begin
                    second_c = c; second_d = resp_rdata;
                    break;
                end
            end
        end
        req_valid = 1'b0;
        chk("b2b_first_cycle",  32'(first_c),  32'd2);
        chk("b2b_first_data",   first_d,  32'hDEAD_BEEF);
        chk("b2b_second_cycle", 32'(second_c), 32'd5);
        chk("b2b_second_data",  second_d, 32'hABCD_F080);

        // Reset while the RMW read is on the memory port.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h0000_0041; req_wdata = 32'h0000_00EE;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        wr_cnt = 0;
        resp_before = resp_cnt;
        @(negedge clk);
        chk("rmw_rst_read_seen", {31'h0, mem_read}, 32'h1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rmw_rst_ready",   {31'h0, req_ready},  32'h1);
        chk("rmw_rst_resp",    {30'h0, resp_valid, resp_err}, 32'h0);
        chk("rmw_rst_mem_rw",  {30'h0, mem_read, mem_write}, 32'h0);
        chk("rmw_rst_rdata",   resp_rdata, 32'h0);
        chk("rmw_rst_addr",    mem_address, 32'h0);
        chk("rmw_rst_wdata",   mem_write_data, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rmw_rst_no_write", 32'(wr_cnt), 32'd0);
        chk("rmw_rst_no_resp",  32'(resp_cnt - resp_before), 32'd0);
        chk("rmw_rst_ready_after", {31'h0, req_ready}, 32'h1);
        run_vec('{1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0, 32'h5566_7788, 1'b0, 2, 1, 0}, 99);

        chk("rw_overlap", 32'(overlap), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
